// File: rtl/vram_banked_arb_if.sv
// Request/response bundle for the two-port banked VRAM.
// Port A is read/write with byte enables; port B is a read-only fetch port.
interface vram_banked_arb_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic              a_req;
  logic              a_write;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_wrdata;
  logic [DW/8-1:0]   a_wrbytesel;
  logic              a_ack;
  logic [DW-1:0]     a_rddata;
  logic              a_rdvalid;

  logic              b_req;
  logic [AW-1:0]     b_addr;
  logic              b_ack;
  logic [DW-1:0]     b_rddata;
  logic              b_rdvalid;

  modport master (
    output a_req, a_write, a_addr, a_wrdata, a_wrbytesel, b_req, b_addr,
    input  a_ack, a_rddata, a_rdvalid, b_ack, b_rddata, b_rdvalid
  );

  modport slave (
    input  a_req, a_write, a_addr, a_wrdata, a_wrbytesel, b_req, b_addr,
    output a_ack, a_rddata, a_rdvalid, b_ack, b_rddata, b_rdvalid
  );
endinterface

// File: rtl/vram_banked_arb.sv
// Banked video RAM: port A (CPU, read/write) and port B (fetch, read-only),
// parallel access to distinct banks, A-priority with a starvation guard for B.
module vram_banked_arb #(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_AW   = 14,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_WAIT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  vram_banked_arb_if.slave   bus
);

  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned AW        = BANK_AW + BANK_BITS;
  localparam int unsigned BEW       = DW / 8;
  localparam int unsigned DEPTH     = 1 << BANK_AW;
  localparam int unsigned CW        = 4;

  // Elaboration-time parameter legality checks
  generate
    if ((NUM_BANKS < 2) || (NUM_BANKS > 8) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_banks
      $error("vram_banked_arb: NUM_BANKS must be a power of two in 2..8");
    end
    if ((DW == 0) || ((DW % 8) != 0)) begin : g_bad_dw
      $error("vram_banked_arb: DW must be a non-zero multiple of 8");
    end
    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_wait
      $error("vram_banked_arb: MAX_WAIT must be in 1..15");
    end
  endgenerate

  logic [BANK_BITS-1:0] a_bank;
  logic [BANK_BITS-1:0] b_bank;
  logic [BANK_AW-1:0]   a_laddr;
  logic [BANK_AW-1:0]   b_laddr;

  assign a_bank  = bus.a_addr[AW-1:BANK_AW];
  assign b_bank  = bus.b_addr[AW-1:BANK_AW];
  assign a_laddr = bus.a_addr[BANK_AW-1:0];
  assign b_laddr = bus.b_addr[BANK_AW-1:0];

  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_nxt;
  logic          force_b;
  logic          conflict;
  logic          a_ack_c;
  logic          b_ack_c;

  // Same-bank arbitration: A wins unless B has waited long enough
  always_comb begin
    force_b  = (wait_q >= CW'(MAX_WAIT));
    conflict = bus.a_req && bus.b_req && (a_bank == b_bank);
    a_ack_c  = bus.a_req && !(conflict && force_b);
    b_ack_c  = bus.b_req && !(conflict && !force_b);
  end

  assign bus.a_ack = a_ack_c;
  assign bus.b_ack = b_ack_c;

  // Starvation counter: counts denied B cycles, saturating
  always_comb begin
    wait_nxt = wait_q;
    if (b_ack_c) begin
      wait_nxt = '0;
    end else if (bus.b_req && (wait_q != {CW{1'b1}})) begin
      wait_nxt = wait_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_nxt;
    end
  end

  logic a_rd_acc;
  logic b_rd_acc;

  assign a_rd_acc = a_ack_c && !bus.a_write;
  assign b_rd_acc = b_ack_c;

  logic [NUM_BANKS-1:0][DW-1:0] bank_dout;

  // One single-port bank per index; arbitration guarantees at most one user
  generate
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] dout;
      logic          a_sel;
      logic          b_sel;

      assign a_sel = a_ack_c && (a_bank == BANK_BITS'(k));
      assign b_sel = b_ack_c && (b_bank == BANK_BITS'(k));

      always_ff @(posedge clk) begin
        if (a_sel && bus.a_write) begin
          for (int unsigned i = 0; i < BEW; i++) begin
            if (bus.a_wrbytesel[i]) begin
              mem[a_laddr][8*i +: 8] <= bus.a_wrdata[8*i +: 8];
            end
          end
        end
        if (a_sel && !bus.a_write) begin
          dout <= mem[a_laddr];
        end else if (b_sel) begin
          dout <= mem[b_laddr];
        end
      end

      assign bank_dout[k] = dout;
    end
  endgenerate

  logic [BANK_BITS-1:0] a_bank_q;
  logic [BANK_BITS-1:0] b_bank_q;
  logic                 a_rdvalid_q;
  logic                 b_rdvalid_q;
  logic [DW-1:0]        a_hold_q;
  logic [DW-1:0]        b_hold_q;

  // Per-port bank steering and valid pulse, one cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_bank_q    <= '0;
      b_bank_q    <= '0;
      a_rdvalid_q <= 1'b0;
      b_rdvalid_q <= 1'b0;
    end else begin
      a_rdvalid_q <= a_rd_acc;
      b_rdvalid_q <= b_rd_acc;
      if (a_rd_acc) begin
        a_bank_q <= a_bank;
      end
      if (b_rd_acc) begin
        b_bank_q <= b_bank;
      end
    end
  end

  // Hold registers keep the last delivered word between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (a_rdvalid_q) begin
        a_hold_q <= bank_dout[a_bank_q];
      end
      if (b_rdvalid_q) begin
        b_hold_q <= bank_dout[b_bank_q];
      end
    end
  end

  assign bus.a_rdvalid = a_rdvalid_q;
  assign bus.b_rdvalid = b_rdvalid_q;
  assign bus.a_rddata  = a_rdvalid_q ? bank_dout[a_bank_q] : a_hold_q;
  assign bus.b_rddata  = b_rdvalid_q ? bank_dout[b_bank_q] : b_hold_q;

endmodule

// File: tb/tb_vram_banked_arb.sv
// Scoreboard bench for vram_banked_arb: directed per-cycle vectors push
// expected read data; an independent monitor checks each valid pulse.
module tb_vram_banked_arb;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] a_hold_exp;
  logic [DW-1:0] b_hold_exp;

  vram_banked_arb_if #(.AW(AW), .DW(DW)) bus ();

  vram_banked_arb #(
    .NUM_BANKS(2),
    .BANK_AW  (14),
    .DW       (DW),
    .MAX_WAIT (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One bus cycle: drive both ports, check acks, queue expected read data
  task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic [3:0] as,
                       input logic br, input logic [AW-1:0] ba,
                       input logic ea, input logic eb,
                       input logic [DW-1:0] eda, input logic [DW-1:0] edb);
    @(negedge clk);
    bus.a_req       = ar;
    bus.a_write     = aw;
    bus.a_addr      = aa;
    bus.a_wrdata    = ad;
    bus.a_wrbytesel = as;
    bus.b_req       = br;
    bus.b_addr      = ba;
    #1;
    chk("a_ack", DW'(bus.a_ack), DW'(ea));
    chk("b_ack", DW'(bus.b_ack), DW'(eb));
    if (ea && !aw) qa.push_back('{eda, cyc + 1});
    if (eb) qb.push_back('{edb, cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 4'h0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic a_wr(input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic [3:0] as);
    drive(1, 1, aa, ad, as, 0, '0, 1, 0, '0, '0);
  endtask

  task automatic a_rd(input logic [AW-1:0] aa, input logic [DW-1:0] ed);
    drive(1, 0, aa, '0, 4'h0, 0, '0, 1, 0, ed, '0);
  endtask

  // Monitor: pops on every valid pulse, checks timing, data and hold value
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk("a_rdvalid_in_reset", DW'(bus.a_rdvalid), '0);
      chk("b_rdvalid_in_reset", DW'(bus.b_rdvalid), '0);
    end else begin
      if (bus.a_rdvalid) begin
        if (qa.size() == 0) begin
          chk("a_rdvalid_unexpected", DW'(1), DW'(0));
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_rddata", bus.a_rddata, e.data);
          chk("a_rdvalid_cycle", DW'(cyc), DW'(e.cyc));
          a_hold_exp = e.data;
        end
      end else begin
        if (qa.size() != 0 && qa[0].cyc <= cyc) begin
          chk("a_rdvalid_missing", DW'(0), DW'(1));
          void'(qa.pop_front());
        end
        chk("a_rddata_hold", bus.a_rddata, a_hold_exp);
      end
      if (bus.b_rdvalid) begin
        if (qb.size() == 0) begin
          chk("b_rdvalid_unexpected", DW'(1), DW'(0));
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_rddata", bus.b_rddata, e.data);
          chk("b_rdvalid_cycle", DW'(cyc), DW'(e.cyc));
          b_hold_exp = e.data;
        end
      end else begin
        if (qb.size() != 0 && qb[0].cyc <= cyc) begin
          chk("b_rdvalid_missing", DW'(0), DW'(1));
          void'(qb.pop_front());
        end
        chk("b_rddata_hold", bus.b_rddata, b_hold_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    a_hold_exp = '0;
    b_hold_exp = '0;
    rst_n = 1'b0;
    bus.a_req = 0; bus.a_write = 0; bus.a_addr = '0; bus.a_wrdata = '0;
    bus.a_wrbytesel = '0; bus.b_req = 0; bus.b_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_a_rdvalid", DW'(bus.a_rdvalid), '0);
    chk("reset_b_rdvalid", DW'(bus.b_rdvalid), '0);
    chk("reset_a_rddata", bus.a_rddata, '0);
    chk("reset_b_rddata", bus.b_rddata, '0);
    chk("reset_a_ack", DW'(bus.a_ack), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Full write, partial byte write, read back merged word
    a_wr(15'h0010, 32'hDEADBEEF, 4'b1111);
    a_wr(15'h0010, 32'h000000AA, 4'b0001);
    a_rd(15'h0010, 32'hDEADBEAA);
    idle(2);

    // Zero byte-enable write is acked but leaves the word untouched
    a_wr(15'h0010, 32'h12345678, 4'b0000);
    a_rd(15'h0010, 32'hDEADBEAA);
    idle(2);

    // Parallel access to different banks in the same cycle
    a_wr(15'h0004, 32'h11112222, 4'b1111);
    a_wr(15'h4004, 32'h33334444, 4'b1111);
    drive(1, 0, 15'h0004, '0, 4'h0, 1, 15'h4004, 1, 1, 32'h11112222, 32'h33334444);
    idle(2);

    // B streams eight consecutive words from bank 1 with A idle
    for (int i = 0; i < 8; i++) a_wr(AW'(15'h4000 + i), 32'hB0000000 + 32'(i), 4'b1111);
    for (int i = 0; i < 8; i++)
      drive(0, 0, '0, '0, 4'h0, 1, AW'(15'h4000 + i), 0, 1, '0, 32'hB0000000 + 32'(i));
    idle(3);

    // Same-bank conflict: A wins three cycles, then B is forced in
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++)
        drive(1, 0, 15'h0010, '0, 4'h0, 1, 15'h0004, 1, 0, 32'hDEADBEAA, 32'h11112222);
      drive(1, 0, 15'h0010, '0, 4'h0, 1, 15'h0004, 0, 1, 32'hDEADBEAA, 32'h11112222);
    end
    idle(2);

    // Reset lands on the accept edge of a read: its valid must never appear
    a_rd(15'h0010, 32'hDEADBEAA);
    @(posedge clk);
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    a_hold_exp = '0;
    b_hold_exp = '0;
    bus.a_req = 0;
    bus.b_req = 0;
    #2;
    chk("mid_reset_a_rdvalid", DW'(bus.a_rdvalid), '0);
    chk("mid_reset_a_rddata", bus.a_rddata, '0);
    chk("mid_reset_b_rddata", bus.b_rddata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    a_rd(15'h0010, 32'hDEADBEAA);
    drive(0, 0, '0, '0, 4'h0, 1, 15'h4007, 0, 1, '0, 32'hB0000007);
    idle(3);

    chk("a_queue_drained", DW'(qa.size()), '0);
    chk("b_queue_drained", DW'(qb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
